// File: rtl/decoder_core_pkg.sv
// rtl/decoder_core_pkg.sv - shared CPU constants: src_a codes, ALU codes, opcode fields
package decoder_core_pkg;

  // ALU A-operand sources
  localparam logic [1:0] SRC_STK0 = 2'd0;
  localparam logic [1:0] SRC_FP   = 2'd1;
  localparam logic [1:0] SRC_IP   = 2'd2;
  localparam logic [1:0] SRC_CSTK = 2'd3;

  // ALU operation codes used by the decoder itself
  localparam logic [5:0] ALU_PASS_A = 6'h00;
  localparam logic [5:0] ALU_PASS_B = 6'h0F;
  localparam logic [5:0] ALU_ADD    = 6'h20;
  localparam logic [5:0] ALU_AND    = 6'h10;

  // Immediate field masks
  localparam logic [15:0] MASK_UIMM15 = 16'h7FFF;
  localparam logic [15:0] MASK_JMP    = 16'h0FFE;
  localparam logic [15:0] MASK_BASE   = 16'h03FE;

  // insn[14:12] when insn[15]=1
  typedef enum logic [2:0] {
    OP_JMP  = 3'b000,
    OP_RSV1 = 3'b001,
    OP_LD   = 3'b010,
    OP_ST   = 3'b011,
    OP_PUSH = 3'b100,
    OP_FP   = 3'b101,
    OP_RSV6 = 3'b110,
    OP_EXT  = 3'b111
  } op_e;

  // insn[7:6] selector inside the 11111 memory group
  localparam logic [1:0] MEM_LDD = 2'b11;
  localparam logic [1:0] MEM_STD = 2'b01;

endpackage

// File: rtl/decoder_core_if.sv
// rtl/decoder_core_if.sv - instruction word in, decoded control bundle out
interface decoder_core_if;
  logic [15:0] insn;
  logic        imm;
  logic [15:0] imm_mask;
  logic [1:0]  src_a;
  logic [5:0]  alu_sel;
  logic        wr_stk1;
  logic        load;
  logic        pop;
  logic        push;
  logic        load_stk;
  logic        load_fp;
  logic        load_ip;
  logic        byt;
  logic        wr;

  // Fetch side supplies the instruction and consumes the controls
  modport master (
    output insn,
    input  imm, imm_mask, src_a, alu_sel, wr_stk1, load, pop, push,
           load_stk, load_fp, load_ip, byt, wr
  );

  // Decoder side
  modport slave (
    input  insn,
    output imm, imm_mask, src_a, alu_sel, wr_stk1, load, pop, push,
           load_stk, load_fp, load_ip, byt, wr
  );
endinterface

// File: rtl/decoder_core.sv
// rtl/decoder_core.sv - stateless combinational instruction decoder
module decoder_core
  import decoder_core_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decoder_core_if.slave  bus
);

  op_e w_op;

  // The decoder holds no state; clk/rst and the operand-only insn bits are
  // gathered here so they are visibly consumed without touching any output.
  logic w_unused;
  assign w_unused = ^{clk, rst, bus.insn[9:8], bus.insn[4:2]};

  assign w_op = op_e'(bus.insn[14:12]);

  // Decode insn into the control bundle; everything defaults to 0 (NOP)
  always_comb begin
    bus.imm      = 1'b0;
    bus.imm_mask = 16'h0000;
    bus.src_a    = SRC_STK0;
    bus.alu_sel  = ALU_PASS_A;
    bus.wr_stk1  = 1'b0;
    bus.load     = 1'b0;
    bus.pop      = 1'b0;
    bus.push     = 1'b0;
    bus.load_stk = 1'b0;
    bus.load_fp  = 1'b0;
    bus.load_ip  = 1'b0;
    bus.byt      = 1'b0;
    bus.wr       = 1'b0;

    if (!bus.insn[15]) begin
      // push uimm15
      bus.imm      = 1'b1;
      bus.imm_mask = MASK_UIMM15;
      bus.alu_sel  = ALU_PASS_B;
      bus.push     = 1'b1;
      bus.load_stk = 1'b1;
    end else begin
      case (w_op)
        OP_JMP: begin
          bus.imm      = 1'b1;
          bus.imm_mask = MASK_JMP;
          bus.src_a    = SRC_IP;
          bus.alu_sel  = ALU_ADD;
          bus.load_ip  = 1'b1;
        end
        OP_LD: begin
          bus.imm      = 1'b1;
          bus.imm_mask = MASK_BASE;
          bus.src_a    = bus.insn[11:10];
          bus.alu_sel  = ALU_ADD;
          bus.load     = 1'b1;
          bus.push     = 1'b1;
          bus.load_stk = 1'b1;
          bus.byt      = bus.insn[0];
        end
        OP_ST: begin
          // store data comes from stk0, so wr_stk1 stays 0
          bus.imm      = 1'b1;
          bus.imm_mask = MASK_BASE;
          bus.src_a    = bus.insn[11:10];
          bus.alu_sel  = ALU_ADD;
          bus.pop      = 1'b1;
          bus.wr       = 1'b1;
          bus.byt      = bus.insn[0];
        end
        OP_PUSH: begin
          bus.imm      = 1'b1;
          bus.imm_mask = MASK_BASE;
          bus.src_a    = bus.insn[11:10];
          bus.alu_sel  = ALU_ADD;
          bus.push     = 1'b1;
          bus.load_stk = 1'b1;
        end
        OP_FP: begin
          bus.imm      = 1'b1;
          bus.imm_mask = MASK_BASE;
          bus.src_a    = bus.insn[11:10];
          bus.alu_sel  = ALU_ADD;
          bus.load_fp  = 1'b1;
        end
        OP_EXT: begin
          if (!bus.insn[11]) begin
            // register ALU op: binary consumes stk1 (pop), unary rewrites stk0
            bus.alu_sel = bus.insn[5:0];
            if (bus.insn[6]) begin
              bus.pop = 1'b1;
            end else begin
              bus.load_stk = 1'b1;
            end
          end else begin
            case (bus.insn[7:6])
              MEM_LDD: begin
                bus.alu_sel  = ALU_PASS_A;
                bus.load     = 1'b1;
                bus.load_stk = 1'b1;
                bus.byt      = bus.insn[0];
              end
              MEM_STD: begin
                // insn[1] keeps the address on the stack (sta) instead of dropping it
                bus.alu_sel  = ALU_PASS_A;
                bus.wr_stk1  = 1'b1;
                bus.pop      = 1'b1;
                bus.wr       = 1'b1;
                bus.load_stk = bus.insn[1];
                bus.byt      = bus.insn[0];
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_core.sv
// tb/tb_decoder_core.sv - directed self-checking bench for decoder_core
module tb_decoder_core;
  import decoder_core_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  decoder_core_if dut_if ();

  decoder_core dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imm, imm_mask, src_a, alu_sel, wr_stk1, load, pop, push, load_stk, load_fp, load_ip, byt, wr}
  function automatic logic [33:0] obs();
    return {dut_if.imm, dut_if.imm_mask, dut_if.src_a, dut_if.alu_sel,
            dut_if.wr_stk1, dut_if.load, dut_if.pop, dut_if.push,
            dut_if.load_stk, dut_if.load_fp, dut_if.load_ip, dut_if.byt, dut_if.wr};
  endfunction

  task automatic apply(input logic [15:0] v);
    @(negedge clk);
    dut_if.insn = v;
    #2;
  endtask

  task automatic test_reset();
    logic [33:0] got;
    rst = 1'b1;
    apply(16'h0BEF);
    got = obs();
    n_cmp++;
    if (got !== {1'b1, 16'h7FFF, 2'd0, 6'h0F, 9'b000110000}) begin
      n_fail++;
      $display("FAIL reset_decode insn=0BEF got=%h want=%h", got,
               {1'b1, 16'h7FFF, 2'd0, 6'h0F, 9'b000110000});
    end
    rst = 1'b0;
  endtask

  task automatic test_push_imm();
    logic [15:0] ins [3];
    logic [33:0] got;
    ins[0] = 16'h0BEF; ins[1] = 16'h0000; ins[2] = 16'h7FFF;
    for (int i = 0; i < 3; i++) begin
      apply(ins[i]);
      got = obs();
      n_cmp++;
      if (got !== {1'b1, 16'h7FFF, 2'd0, 6'h0F, 9'b000110000}) begin
        n_fail++;
        $display("FAIL push_imm insn=%h got=%h want=%h", ins[i], got,
                 {1'b1, 16'h7FFF, 2'd0, 6'h0F, 9'b000110000});
      end
    end
  endtask

  task automatic test_imm_ops();
    logic [15:0] ins [7];
    logic [33:0] exp [7];
    logic [33:0] got;
    ins[0] = 16'h8020; exp[0] = {1'b1, 16'h0FFE, 2'd2, 6'h20, 9'b000000100};
    ins[1] = 16'hB430; exp[1] = {1'b1, 16'h03FE, 2'd1, 6'h20, 9'b001000001};
    ins[2] = 16'hB431; exp[2] = {1'b1, 16'h03FE, 2'd1, 6'h20, 9'b001000011};
    ins[3] = 16'hA80B; exp[3] = {1'b1, 16'h03FE, 2'd2, 6'h20, 9'b010110010};
    ins[4] = 16'hCC00; exp[4] = {1'b1, 16'h03FE, SRC_CSTK, 6'h20, 9'b000110000};
    ins[5] = 16'hD400; exp[5] = {1'b1, 16'h03FE, 2'd1, 6'h20, 9'b000001000};
    ins[6] = 16'hA000; exp[6] = {1'b1, 16'h03FE, 2'd0, 6'h20, 9'b010110000};
    for (int i = 0; i < 7; i++) begin
      apply(ins[i]);
      got = obs();
      n_cmp++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL imm_op insn=%h got=%h want=%h", ins[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_alu();
    logic [15:0] ins [3];
    logic [33:0] exp [3];
    logic [33:0] got;
    ins[0] = 16'hF050; exp[0] = {1'b0, 16'h0000, 2'd0, ALU_AND, 9'b001000000};
    ins[1] = 16'hF003; exp[1] = {1'b0, 16'h0000, 2'd0, 6'h03, 9'b000010000};
    ins[2] = 16'hF07F; exp[2] = {1'b0, 16'h0000, 2'd0, 6'h3F, 9'b001000000};
    for (int i = 0; i < 3; i++) begin
      apply(ins[i]);
      got = obs();
      n_cmp++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL alu_op insn=%h got=%h want=%h", ins[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_mem();
    logic [15:0] ins [5];
    logic [33:0] exp [5];
    logic [33:0] got;
    ins[0] = 16'hF8C0; exp[0] = {1'b0, 16'h0000, 2'd0, 6'h00, 9'b010010000};
    ins[1] = 16'hF840; exp[1] = {1'b0, 16'h0000, 2'd0, 6'h00, 9'b101000001};
    ins[2] = 16'hF846; exp[2] = {1'b0, 16'h0000, 2'd0, 6'h00, 9'b101010001};
    ins[3] = 16'hF8C1; exp[3] = {1'b0, 16'h0000, 2'd0, 6'h00, 9'b010010010};
    ins[4] = 16'hF841; exp[4] = {1'b0, 16'h0000, 2'd0, 6'h00, 9'b101000011};
    for (int i = 0; i < 5; i++) begin
      apply(ins[i]);
      got = obs();
      n_cmp++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL mem_op insn=%h got=%h want=%h", ins[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_nop();
    logic [15:0] ins [5];
    logic [33:0] got;
    ins[0] = 16'h9000; ins[1] = 16'hE000; ins[2] = 16'hF800;
    ins[3] = 16'hF880; ins[4] = 16'h9FFF;
    for (int i = 0; i < 5; i++) begin
      apply(ins[i]);
      got = obs();
      n_cmp++;
      if (got !== 34'd0) begin
        n_fail++;
        $display("FAIL nop insn=%h got=%h want=%h", ins[i], got, 34'd0);
      end
    end
  endtask

  task automatic test_rst_toggle();
    logic [15:0] ins [3];
    logic [33:0] exp [3];
    logic [33:0] got;
    ins[0] = 16'hB430; exp[0] = {1'b1, 16'h03FE, 2'd1, 6'h20, 9'b001000001};
    ins[1] = 16'hF846; exp[1] = {1'b0, 16'h0000, 2'd0, 6'h00, 9'b101010001};
    ins[2] = 16'hE000; exp[2] = 34'd0;
    for (int i = 0; i < 3; i++) begin
      rst = 1'b0;
      apply(ins[i]);
      rst = 1'b1;
      @(posedge clk);
      #2;
      got = obs();
      n_cmp++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL rst_toggle insn=%h got=%h want=%h", ins[i], got, exp[i]);
      end
      rst = 1'b0;
      @(posedge clk);
      #2;
      got = obs();
      n_cmp++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL rst_release insn=%h got=%h want=%h", ins[i], got, exp[i]);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    dut_if.insn = 16'h0000;
    test_reset();
    test_push_imm();
    test_imm_ops();
    test_alu();
    test_mem();
    test_nop();
    test_rst_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_core.md
DECODER_CORE -- requirements
Module: decoder

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit; the block has one clock domain.
REQ-002 SHALL have reset `rst`, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have `insn`, input, 16 bits: the current instruction word.
REQ-004 SHALL have `imm`, output, 1 bit: the instruction carries an immediate.
REQ-005 SHALL have `imm_mask`, output, 16 bits: selects the immediate bits of `insn`.
REQ-006 SHALL have `src_a`, output, 2 bits: ALU A source (0 stk0, 1 fp, 2 ip, 3 cstk).
REQ-007 SHALL have `alu_sel`, output, 6 bits: ALU operation.
REQ-008 SHALL have `wr_stk1`, output, 1 bit: memory write data comes from stk1, not stk0.
REQ-009 SHALL have `load`, output, 1 bit: memory read.
REQ-010 SHALL have `pop`, output, 1 bit: stack pop.
REQ-011 SHALL have `push`, output, 1 bit: stack push.
REQ-012 SHALL have `load_stk`, output, 1 bit: write stk0.
REQ-013 SHALL have `load_fp`, output, 1 bit: write fp.
REQ-014 SHALL have `load_ip`, output, 1 bit: write ip.
REQ-015 SHALL have `byt`, output, 1 bit: byte-sized memory access.
REQ-016 SHALL have `wr`, output, 1 bit: memory write.

Function
REQ-017 SHALL be purely combinational from `insn` to every output, with zero-cycle latency and no dependence on `clk` or `rst`.
REQ-018 SHALL drive every output not named in a row below to 0, including `imm_mask` when `imm`=0, `byt` outside memory ops, and `src_a`=0.
REQ-019 SHALL use these ALU codes: 0x00 pass A, 0x0F pass B (immediate), 0x20 add, 0x10 and; for register ALU ops, `alu_sel` is taken from `insn[5:0]`.
REQ-020 insn[15]=0 (push uimm15) SHALL drive: imm=1, mask=0x7FFF, alu=0x0F, push=1, load_stk=1.
REQ-021 insn[15:12]=1000 (jmp ip+off) SHALL drive: imm=1, mask=0x0FFE, src_a=2, alu=0x20, load_ip=1.
REQ-022 insn[15:12]=1010 (ld base+off) SHALL drive: imm=1, mask=0x03FE, src_a=insn[11:10], alu=0x20, load=1, push=1, load_stk=1, byt=insn[0].
REQ-023 insn[15:12]=1011 (st base+off) SHALL drive: same address fields as ld, pop=1, wr=1, wr_stk1=0, byt=insn[0].
REQ-024 insn[15:12]=1100 (push base+off) SHALL drive: imm=1, mask=0x03FE, src_a=insn[11:10], alu=0x20, push=1, load_stk=1.
REQ-025 insn[15:12]=1101 (fp = base+off) SHALL drive: imm=1, mask=0x03FE, src_a=insn[11:10], alu=0x20, load_fp=1.
REQ-026 insn[15:12]=1111 with insn[11]=0 (ALU op) SHALL drive: src_a=0, alu=insn[5:0]; if insn[6]=1 (binary), pop=1 and load_stk=0; otherwise (unary), load_stk=1.
REQ-027 insn[15:11]=11111 with insn[7:6]=11 (ldd) SHALL drive: alu=0x00, load=1, load_stk=1, byt=insn[0].
REQ-028 insn[15:11]=11111 with insn[7:6]=01 (std/sta) SHALL drive: alu=0x00, wr_stk1=1, pop=1, wr=1, load_stk=insn[1], byt=insn[0].
REQ-029 All other encodings (1001, 1110, 11111 with insn[6]=0) SHALL decode as NOP, with all outputs 0.

Reset
REQ-030 The block SHALL hold no state; `rst` SHALL NOT alter any output, and outputs SHALL be valid in every cycle, including during reset.

Structure
REQ-031 A shared CPU package SHALL hold the src_a codes, ALU codes, and opcode-field constants.
REQ-032 There SHALL be no sub-module; the decode is a single combinational block.

Verification
REQ-033 insn=0x0BEF -> imm=1, mask=0x7FFF, alu=0x0F, push=1, load_stk=1; load, pop, load_fp, load_ip, wr all 0.
REQ-034 insn=0x8020 -> imm=1, mask=0x0FFE, src_a=2, alu=0x20, load_ip=1; all other controls 0.
REQ-035 insn=0xB430 -> imm=1, mask=0x03FE, src_a=1, alu=0x20, pop=1, wr=1; wr_stk1=0, byt=0, push=0, load_stk=0.
REQ-036 insn=0xF050 -> imm=0, src_a=0, alu=0x10, pop=1; load_stk=0, wr=0.
REQ-037 Memory ops: insn=0xF8C0 -> load=1, load_stk=1, alu=0x00; insn=0xF840 -> wr_stk1=1, pop=1, wr=1, load_stk=0; insn=0xF846 -> same as 0xF840 but load_stk=1; byt=0 for all three.
REQ-038 insn=0x9000 and insn=0xE000 -> all outputs 0; toggling `rst` during any vector leaves outputs unchanged.
